// File: rtl/mem_arbiter.sv
// Memory arbiter: shares one single-outstanding memory port between an
// instruction-fetch port and a data load/store port. Data normally wins, but a
// starve counter forces a fetch grant after STARVE_MAX data grants that were
// issued while a fetch was waiting.
//
// Handshakes: a requester holds x_req (and its address/data) until x_gnt is
// high in a cycle; the request is consumed at that rising edge. The memory side
// holds mem_req/mem_addr/mem_we/mem_wdata stable until a cycle with mem_ready
// high, which completes the access; x_valid pulses for one cycle afterwards.
module mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_pin,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_valid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_valid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        dbg_state_o
);

   localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                we_q;
   logic [CNT_W-1:0]    starve_q;
   logic [CNT_W-1:0]    starve_d;
   logic                if_valid_q;
   logic                d_valid_q;
   logic [DATA_W-1:0]   if_rdata_q;
   logic [DATA_W-1:0]   d_rdata_q;
   logic                fetch_forced;

   // Grant decision (IDLE only) and starve counter next value.
   always_comb begin
      if_gnt       = 1'b0;
      d_gnt        = 1'b0;
      fetch_forced = if_req && (starve_q == STARVE_LIM);
      starve_d     = starve_q;
      if (state_q == IDLE) begin
         d_gnt  = d_req && !fetch_forced;
         if_gnt = if_req && !d_gnt;
      end
      if (if_gnt) begin
         starve_d = '0;
      end else if (d_gnt && if_req && (starve_q != STARVE_LIM)) begin
         starve_d = starve_q + CNT_W'(1);
      end
   end

   // Arbiter FSM: latches the granted request, runs the memory access and
   // registers the returned data and completion pulses.
   always_ff @(posedge clk or negedge rst_pin) begin
      if (!rst_pin) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         starve_q   <= '0;
         if_valid_q <= 1'b0;
         d_valid_q  <= 1'b0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         if_valid_q <= 1'b0;
         d_valid_q  <= 1'b0;
         starve_q   <= starve_d;
         case (state_q)
            IDLE: begin
               if (d_gnt) begin
                  state_q <= BUSY_D;
                  addr_q  <= d_addr;
                  wdata_q <= d_wdata;
                  we_q    <= d_we;
               end else if (if_gnt) begin
                  state_q <= BUSY_I;
                  addr_q  <= if_addr;
                  wdata_q <= '0;
                  we_q    <= 1'b0;
               end
            end
            BUSY_I: begin
               if (mem_ready) begin
                  if_rdata_q <= mem_rdata;
                  if_valid_q <= 1'b1;
                  state_q    <= IDLE;
               end
            end
            BUSY_D: begin
               if (mem_ready) begin
                  // Stores leave the last load value visible on d_rdata.
                  if (!we_q) begin
                     d_rdata_q <= mem_rdata;
                  end
                  d_valid_q <= 1'b1;
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Memory side is driven purely from latched registers and the state.
   always_comb begin
      mem_req     = (state_q != IDLE);
      mem_we      = (state_q == BUSY_D) && we_q;
      mem_addr    = addr_q;
      mem_wdata   = wdata_q;
      if_valid    = if_valid_q;
      d_valid     = d_valid_q;
      if_rdata    = if_rdata_q;
      d_rdata     = d_rdata_q;
      dbg_state_o = state_q;
   end

endmodule
